// File: rtl/insync4_frame_config_mux.sv
// ---------------------------------------------------------------------------
// insync4_frame_config_mux
//
// Four-channel input-conditioning BEL for the RAM_IO tile. Each external pin
// goes through a 2-flop synchronizer, a stability filter (deglitcher) and a
// rising-edge detector. A 2-bit mode per channel, taken from the frame
// configuration bits, selects which of these stages drives the output.
//
// Ports
//   UserCLK     in   1             user clock, rising edge
//   resetn      in   1             asynchronous active-low reset
//   I           in   4             external asynchronous inputs, one per channel
//   O           out  4             conditioned outputs to the fabric
//   ConfigBits  in   NoConfigBits  frame config:
//                                    [2i+1:2i] mode of channel i
//                                      00 bypass (O=I), 01 synced level,
//                                      10 filtered level, 11 rising-edge pulse
//                                    [9:8] filter threshold N: 2/4/8/16
// ---------------------------------------------------------------------------
module insync4_frame_config_mux #(
  parameter int NoConfigBits = 10
) (
  input  logic                    UserCLK,
  input  logic                    resetn,
  input  logic [3:0]              I,
  output logic [3:0]              O,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  // N-1 for the shared filter threshold; the counter commits once cnt >= N-1.
  // A ">=" compare means lowering N mid-count commits on the next edge
  // instead of letting the counter run on and wrap.
  logic [3:0] thresh_m1_s;

  // Decode the shared threshold select into N-1.
  always_comb begin
    thresh_m1_s = 4'd1;
    case (ConfigBits[9:8])
      2'b00:   thresh_m1_s = 4'd1;
      2'b01:   thresh_m1_s = 4'd3;
      2'b10:   thresh_m1_s = 4'd7;
      2'b11:   thresh_m1_s = 4'd15;
      default: thresh_m1_s = 4'd1;
    endcase
  end

  for (genvar g = 0; g < 4; g++) begin : g_ch
    // sync_s1_q/sync_s2_q form a bare flop pair with nothing between them so
    // the synchronizer can be located by name in timing constraints.
    logic       sync_s1_q;
    logic       sync_s2_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       filt_q;
    logic       filt_d;
    logic       filt_dly_q;
    logic       ch_out_s;

    // Two-flop synchronizer for the asynchronous pin.
    always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
        sync_s1_q <= 1'b0;
        sync_s2_q <= 1'b0;
      end else begin
        sync_s1_q <= I[g];
        sync_s2_q <= sync_s1_q;
      end
    end

    // Stability filter: any edge where the synced input agrees with the
    // filtered value clears the count, so a short excursion is discarded.
    always_comb begin
      cnt_d  = cnt_q;
      filt_d = filt_q;
      if (sync_s2_q == filt_q) begin
        cnt_d = 4'd0;
      end else if (cnt_q >= thresh_m1_s) begin
        filt_d = sync_s2_q;
        cnt_d  = 4'd0;
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end

    // Filter state and the one-cycle-delayed copy used for edge detection.
    always_ff @(posedge UserCLK or negedge resetn) begin
      if (!resetn) begin
        cnt_q      <= 4'd0;
        filt_q     <= 1'b0;
        filt_dly_q <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        filt_q     <= filt_d;
        filt_dly_q <= filt_q;
      end
    end

    // Output select; bypass is purely combinational so it works in reset.
    always_comb begin
      ch_out_s = 1'b0;
      case (ConfigBits[2*g+1:2*g])
        2'b00:   ch_out_s = I[g];
        2'b01:   ch_out_s = sync_s2_q;
        2'b10:   ch_out_s = filt_q;
        2'b11:   ch_out_s = filt_q & ~filt_dly_q;
        default: ch_out_s = 1'b0;
      endcase
    end

    assign O[g] = ch_out_s;
  end

endmodule

// File: doc/insync4_frame_config_mux.md
INSYNC4_FRAME_CONFIG_MUX -- requirements
Module: insync4_frame_config_mux

Purpose: 4-channel input-conditioning BEL for the RAM_IO tile. It sits between the external pins and the input-pass BEL: synchronize, deglitch and edge-detect, with mode set by frame config bits.

Interface
REQ-001 Parameter: NoConfigBits, 10, width of ConfigBits.
REQ-002 Port: UserCLK  input  1  user clock, rising edge; shared port exported to top.
REQ-003 Port: resetn  input  1  asynchronous, active-low reset.
REQ-004 Port: I  input  4  external asynchronous inputs, one per channel.
REQ-005 Port: O  output  4  conditioned outputs to the fabric / downstream input-pass BEL.
REQ-006 Port: ConfigBits  input  NoConfigBits  global frame configuration, static in normal use.
REQ-007 The block SHALL use one clock (UserCLK) and an asynchronous active-low reset (resetn); no other clock or reset.

Function
REQ-008 ConfigBits[2i+1:2i] SHALL select the mode of channel i: 00 bypass, 01 synced level, 10 filtered level, 11 rising-edge pulse.
REQ-009 ConfigBits[9:8] SHALL select the filter threshold N, shared by all channels: 00->2, 01->4, 10->8, 11->16 cycles.
REQ-010 Each channel SHALL have a 2-flop synchronizer I->s1->s2, so s2 lags I by 2 edges.
REQ-011 Each channel SHALL have a 4-bit stability counter cnt and a filtered bit filt.
REQ-012 Each edge, per channel: if s2==filt then cnt<=0; else if cnt>=N-1 then filt<=s2 and cnt<=0; else cnt<=cnt+1.
REQ-013 filt SHALL therefore change exactly N edges after s2 changes, provided s2 stays stable for those N edges. A shorter excursion SHALL be discarded and SHALL reset cnt.
REQ-014 Each channel SHALL register filt_d<=filt every edge.
REQ-015 Per-channel output: mode 00 O=I (combinational, zero latency); 01 O=s2; 10 O=filt; 11 O=filt & ~filt_d.
REQ-016 Mode 11 SHALL produce exactly one UserCLK cycle high per filt rising transition and nothing on falling transitions.
REQ-017 Latency from a stable I change to O: mode 01 = 2 edges; mode 10 = 2+N edges; mode 11 = pulse visible after edge 2+N, cleared after edge 3+N.
REQ-018 A mode change SHALL take effect combinationally; internal state SHALL continue updating regardless of mode.
REQ-019 A threshold change mid-count SHALL apply immediately. Because the compare is >=, a cnt already at or above the new N-1 SHALL commit on the next edge; the counter SHALL never wrap.
REQ-020 Channels SHALL be fully independent; simultaneous events on several channels SHALL not interact.
REQ-021 The synchronizer flops SHALL be instantiated so they remain identifiable for timing constraints (no logic between s1 and s2).

Reset
REQ-022 While resetn is low, the block SHALL asynchronously force s1, s2, cnt, filt and filt_d to 0.
REQ-023 During reset, O SHALL be 0 for modes 01/10/11; mode 00 SHALL still follow I.
REQ-024 On resetn deassertion, operation SHALL start on the next UserCLK rising edge with no spurious mode-11 pulse.
REQ-025 Reset asserted mid-count SHALL discard the pending transition. If I is still 1 after release, filt SHALL rise 2+N edges after release.

Verification
REQ-026 Mode 01 on all channels, I=4'b0000->4'b1010 at edge 0 -> O=4'b1010 after edge 2, not before.
REQ-027 Mode 10, N=4, I[0] 0->1 held -> O[0] rises after edge 6. Separately, a 3-cycle I[0] high pulse -> O[0] stays 0 and cnt returns to 0.
REQ-028 Mode 11, N=2, I[2] 0->1 held, later 1->0 -> O[2] high exactly one cycle (after edge 4, low after edge 5); no pulse on the falling edge.
REQ-029 Mode 10, N=16, with cnt=9 switch ConfigBits[9:8] to 01 (N=4) -> filt commits on the next edge.
REQ-030 Mode 10, N=8, resetn pulsed low at cnt=5 with I held 1 -> O=0 during reset, then O rises 10 edges after release. Mode 00 channels track I throughout.
